// File: rtl/shared_data_memory.sv
// shared_data_memory: two-port shared .data memory for the dual-core MIPS build.
// Combinational reads, clocked writes, port 1 wins same-index write collisions.
// Reads during a write return the old word; the new word is visible next cycle.
// Optional hardware semaphore at LOCK_ADDR, enabled by defining SHARED_MEM_LOCK_EN.
// The array has no reset and no init logic so a simulation preload survives reset.
module shared_data_memory #(
  parameter int unsigned         W_CPU     = 32,
  parameter int unsigned         W_MEM_CMD = 2,
  parameter int unsigned         ADDR_BITS = 12,
  parameter logic [W_CPU-1:0]    LOCK_ADDR = 32'h0000_3FFC
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [W_MEM_CMD-1:0] mem_cmd_1,
  input  logic [W_CPU-1:0]     data_in_1,
  input  logic [W_CPU-1:0]     data_addr_1,
  output logic [W_CPU-1:0]     data_out_1,
  input  logic [W_MEM_CMD-1:0] mem_cmd_2,
  input  logic [W_CPU-1:0]     data_in_2,
  input  logic [W_CPU-1:0]     data_addr_2,
  output logic [W_CPU-1:0]     data_out_2
);

  localparam logic [W_MEM_CMD-1:0] CMD_READ  = W_MEM_CMD'(1);
  localparam logic [W_MEM_CMD-1:0] CMD_WRITE = W_MEM_CMD'(2);

  logic [W_CPU-1:0] r_mem [2**ADDR_BITS];

  logic [ADDR_BITS-1:0] w_idx_1, w_idx_2;
  logic                 w_rd_1, w_rd_2, w_wr_1, w_wr_2;
  logic                 w_we_1, w_we_2;
  logic                 w_lk_1, w_lk_2;
  logic [W_CPU-1:0]     w_lock_q_1, w_lock_q_2;
  logic                 w_unused;

  // Byte lanes and bits above the array span are ignored: addresses wrap.
  assign w_idx_1 = data_addr_1[ADDR_BITS+1:2];
  assign w_idx_2 = data_addr_2[ADDR_BITS+1:2];

  // Reset low blocks reads and writes alike.
  assign w_rd_1 = reset && (mem_cmd_1 == CMD_READ);
  assign w_rd_2 = reset && (mem_cmd_2 == CMD_READ);
  assign w_wr_1 = reset && (mem_cmd_1 == CMD_WRITE);
  assign w_wr_2 = reset && (mem_cmd_2 == CMD_WRITE);

  assign w_unused = ^{data_addr_1[W_CPU-1:ADDR_BITS+2], data_addr_1[1:0],
                      data_addr_2[W_CPU-1:ADDR_BITS+2], data_addr_2[1:0], LOCK_ADDR};

`ifdef SHARED_MEM_LOCK_EN
  localparam logic [ADDR_BITS-1:0] LOCK_IDX = LOCK_ADDR[ADDR_BITS+1:2];

  logic r_lock;
  logic r_owner;  // 0: port 1 holds the lock, 1: port 2 holds it

  assign w_lk_1 = (w_idx_1 == LOCK_IDX);
  assign w_lk_2 = (w_idx_2 == LOCK_IDX);

  // Port 2 sees the lock as taken when port 1 wins a simultaneous test-and-set.
  assign w_lock_q_1 = {{(W_CPU-1){1'b0}}, r_lock};
  assign w_lock_q_2 = {{(W_CPU-1){1'b0}}, r_lock | (w_rd_1 && w_lk_1)};

  // Semaphore: read of a free lock takes it (port 1 first); owner write frees it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_lock  <= 1'b0;
      r_owner <= 1'b0;
    end else if (!r_lock) begin
      if (w_rd_1 && w_lk_1) begin
        r_lock  <= 1'b1;
        r_owner <= 1'b0;
      end else if (w_rd_2 && w_lk_2) begin
        r_lock  <= 1'b1;
        r_owner <= 1'b1;
      end
    end else if ((w_wr_1 && w_lk_1 && !r_owner) || (w_wr_2 && w_lk_2 && r_owner)) begin
      r_lock <= 1'b0;
    end
  end
`else
  assign w_lk_1     = 1'b0;
  assign w_lk_2     = 1'b0;
  assign w_lock_q_1 = '0;
  assign w_lock_q_2 = '0;
`endif

  // Lock word is not array-backed; port 2 yields to port 1 on a same-index write.
  assign w_we_1 = w_wr_1 && !w_lk_1;
  assign w_we_2 = w_wr_2 && !w_lk_2 && !(w_we_1 && (w_idx_1 == w_idx_2));

  // Array writes; no reset so preloaded contents are preserved.
  always_ff @(posedge clk) begin
    if (w_we_1) r_mem[w_idx_1] <= data_in_1;
    if (w_we_2) r_mem[w_idx_2] <= data_in_2;
  end

  // Port 1 read data: stored word (or lock bit) on READ, zero otherwise.
  always_comb begin
    data_out_1 = '0;
    if (w_rd_1) data_out_1 = w_lk_1 ? w_lock_q_1 : r_mem[w_idx_1];
  end

  // Port 2 read data: stored word (or lock bit) on READ, zero otherwise.
  always_comb begin
    data_out_2 = '0;
    if (w_rd_2) data_out_2 = w_lk_2 ? w_lock_q_2 : r_mem[w_idx_2];
  end

endmodule

// File: tb/tb_shared_data_memory.sv
// Directed bench for shared_data_memory with a word-level reference model.
// Define SHARED_MEM_LOCK_EN to also exercise the semaphore.
module tb_shared_data_memory;

  localparam logic [1:0]  NOP = 2'd0, RD = 2'd1, WR = 2'd2, RSV = 2'd3;
  localparam logic [11:0] LOCK_IDX = 12'hFFF;
  localparam logic [31:0] LOCK_A   = 32'h0000_3FFC;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  cmd1 = NOP, cmd2 = NOP;
  logic [31:0] addr1 = '0, addr2 = '0, din1 = '0, din2 = '0;
  logic [31:0] dout1, dout2;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Reference model: word array with per-word "known" flag, plus lock state.
  logic [31:0] m_mem   [4096];
  bit          m_known [4096];
  bit          m_lock  = 1'b0;
  int          m_owner = 0;

  shared_data_memory dut (
    .clk        (clk),
    .reset      (rst_n),
    .mem_cmd_1  (cmd1),
    .data_in_1  (din1),
    .data_addr_1(addr1),
    .data_out_1 (dout1),
    .mem_cmd_2  (cmd2),
    .data_in_2  (din2),
    .data_addr_2(addr2),
    .data_out_2 (dout2)
  );

  always #5 clk = ~clk;

  function automatic bit lock_mode();
`ifdef SHARED_MEM_LOCK_EN
    return 1'b1;
`else
    return 1'b0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected read data for one port as {known, value}.
  function automatic logic [32:0] model_read(input bit p2);
    logic [1:0]  c;
    logic [31:0] a;
    logic [11:0] idx;
    c   = p2 ? cmd2 : cmd1;
    a   = p2 ? addr2 : addr1;
    idx = a[13:2];
    if (rst_n !== 1'b1 || c != RD) return {1'b1, 32'h0};
    if (lock_mode() && idx == LOCK_IDX) begin
      if (p2 && !m_lock && cmd1 == RD && addr1[13:2] == LOCK_IDX) return {1'b1, 32'h1};
      return {1'b1, 31'h0, m_lock};
    end
    return {m_known[idx], m_mem[idx]};
  endfunction

  // Compare both ports against the model once per cycle, away from the edge.
  always @(negedge clk) begin
    logic [32:0] e1, e2;
    if (chk_en) begin
      e1 = model_read(1'b0);
      e2 = model_read(1'b1);
      if (e1[32]) check("model_port1", dout1, e1[31:0]);
      if (e2[32]) check("model_port2", dout2, e2[31:0]);
    end
  end

  // Model state update on the rising edge.
  always @(posedge clk) begin
    bit l1, l2;
    if (rst_n === 1'b1) begin
      l1 = lock_mode() && addr1[13:2] == LOCK_IDX;
      l2 = lock_mode() && addr2[13:2] == LOCK_IDX;
      // Apply port 2 first so a same-word port 1 write overrides it.
      if (cmd2 == WR && !l2) begin
        m_mem[addr2[13:2]] = din2; m_known[addr2[13:2]] = 1'b1;
      end
      if (cmd1 == WR && !l1) begin
        m_mem[addr1[13:2]] = din1; m_known[addr1[13:2]] = 1'b1;
      end
      if (!m_lock) begin
        if (cmd1 == RD && l1) begin m_lock = 1'b1; m_owner = 1; end
        else if (cmd2 == RD && l2) begin m_lock = 1'b1; m_owner = 2; end
      end else if ((cmd1 == WR && l1 && m_owner == 1) || (cmd2 == WR && l2 && m_owner == 2)) begin
        m_lock = 1'b0;
      end
    end
  end

  always @(negedge rst_n) begin
    m_lock  = 1'b0;
    m_owner = 0;
  end

  task automatic step(input logic [1:0] c1, input logic [31:0] a1, input logic [31:0] d1,
                      input logic [1:0] c2, input logic [31:0] a2, input logic [31:0] d2);
    @(posedge clk);
    #1;
    cmd1 = c1; addr1 = a1; din1 = d1;
    cmd2 = c2; addr2 = a2; din2 = d2;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, n_tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    chk_en = 1'b1;
    // Reset state, including a write attempt that must be suppressed.
    step(WR, 32'h2000, 32'h99, RD, 32'h2000, 0);
    check("reset_out1", dout1, 32'h0);
    check("reset_out2", dout2, 32'h0);
    @(posedge clk); #1; rst_n = 1'b1;

    // Preload known contents.
    step(WR, 32'h2000, 32'h5, WR, 32'h2004, 32'h0BAD_0001);
    step(WR, 32'h2014, 32'hAA, NOP, 0, 0);

    // Basic read, NOP port is zero.
    step(RD, 32'h2000, 0, NOP, 32'h2000, 0);
    check("read_preload", dout1, 32'h5);
    check("nop_zero", dout2, 32'h0);

    // Read-during-write returns the old word.
    step(WR, 32'h2004, 32'hDEAD_BEEF, RD, 32'h2004, 0);
    check("rdw_old", dout2, 32'h0BAD_0001);
    check("write_out_zero", dout1, 32'h0);
    step(NOP, 0, 0, RD, 32'h2004, 0);
    check("rdw_new", dout2, 32'hDEAD_BEEF);

    // Same-index collision: port 1 wins.
    step(WR, 32'h2008, 32'h1111_1111, WR, 32'h2008, 32'h2222_2222);
    step(RD, 32'h2008, 0, RD, 32'h2008, 0);
    check("collide_p1", dout1, 32'h1111_1111);
    check("collide_p2", dout2, 32'h1111_1111);

    // Distinct indices: both stored.
    step(WR, 32'h200C, 32'hAAAA_0001, WR, 32'h2010, 32'hBBBB_0002);
    step(RD, 32'h200C, 0, RD, 32'h2010, 0);
    check("dual_p1", dout1, 32'hAAAA_0001);
    check("dual_p2", dout2, 32'hBBBB_0002);

    // Port 1 reads a word port 2 is writing.
    step(RD, 32'h200C, 0, WR, 32'h200C, 32'hCCCC_0003);
    check("rdw_cross_old", dout1, 32'hAAAA_0001);
    step(RD, 32'h200C, 0, NOP, 0, 0);
    check("rdw_cross_new", dout1, 32'hCCCC_0003);

    // Reserved command: no read data, no write.
    step(RSV, 32'h2000, 32'h77, NOP, 0, 0);
    check("reserved_zero", dout1, 32'h0);
    step(RD, 32'h2000, 0, NOP, 0, 0);
    check("reserved_nowrite", dout1, 32'h5);

    // Reset mid-operation with a write pending.
    @(posedge clk); #1;
    cmd1 = WR; addr1 = 32'h2014; din1 = 32'h9;
    cmd2 = RD; addr2 = 32'h2000;
    #1;
    check("pre_reset_read", dout2, 32'h5);
    rst_n = 1'b0;
    #1;
    check("async_reset_out1", dout1, 32'h0);
    check("async_reset_out2", dout2, 32'h0);
    @(posedge clk); #1;
    cmd1 = NOP; cmd2 = NOP;
    @(posedge clk); #1;
    rst_n = 1'b1;
    step(RD, 32'h2014, 0, RD, 32'h2000, 0);
    check("reset_no_write", dout1, 32'hAA);
    check("reset_keeps_mem", dout2, 32'h5);

    // Address aliasing and wrap.
    step(WR, 32'h0000_2003, 32'h7, NOP, 0, 0);
    step(RD, 32'h2000, 0, RD, 32'h0000_6000, 0);
    check("alias_low_bits", dout1, 32'h7);
    check("alias_wrap", dout2, 32'h7);

`ifdef SHARED_MEM_LOCK_EN
    // Simultaneous test-and-set: port 1 granted.
    step(RD, LOCK_A, 0, RD, LOCK_A, 0);
    check("lock_tas_p1", dout1, 32'h0);
    check("lock_tas_p2", dout2, 32'h1);
    step(NOP, 0, 0, RD, LOCK_A, 0);
    check("lock_held", dout2, 32'h1);
    step(NOP, 0, 0, WR, LOCK_A, 32'h0);
    step(RD, LOCK_A, 0, NOP, 0, 0);
    check("lock_nonowner_write", dout1, 32'h1);
    step(WR, LOCK_A, 32'h0, NOP, 0, 0);
    step(NOP, 0, 0, RD, LOCK_A, 0);
    check("lock_owner_clear", dout2, 32'h0);
    step(NOP, 0, 0, RD, LOCK_A, 0);
    check("lock_p2_taken", dout2, 32'h1);
    @(posedge clk); #1;
    cmd1 = NOP; cmd2 = NOP;
    #1 rst_n = 1'b0;
    #2 rst_n = 1'b1;
    step(RD, LOCK_A, 0, NOP, 0, 0);
    check("lock_reset_clear", dout1, 32'h0);
`else
    // Without the lock the semaphore address is plain storage.
    step(WR, LOCK_A, 32'h55, NOP, 0, 0);
    step(RD, LOCK_A, 0, RD, LOCK_A, 0);
    check("lockaddr_plain_p1", dout1, 32'h55);
    check("lockaddr_plain_p2", dout2, 32'h55);
`endif

    step(NOP, 0, 0, NOP, 0, 0);
    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
